// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions the raw push-button pads (fire, left, right, start, pause) for the
// game logic. Each channel is brought into the clk domain by a two-flop
// synchroniser and then filtered. The filtered level changes only after the
// synchronised input has disagreed with it for DEBOUNCE_CYCLES consecutive
// samples. Any agreeing sample restarts the count from zero.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high; clears synchronisers, counters, outputs
//   raw     [N_BTN] asynchronous pad levels, 1 = pressed
//   stable  [N_BTN] debounced level per channel (feeds the press-pulse stage)
//   rise    [N_BTN] one-cycle strobe, registered with the 0->1 flip of stable
//   fall    [N_BTN] one-cycle strobe, registered with the 1->0 flip of stable
//
// Parameters:
//   N_BTN            number of independent channels
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to flip (>= 1)
//   CNT_W            counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//   PRESCALE         sample-tick divider (>= 2), prescaler build only
//
// Build option:
//   BTN_DEBOUNCE_PRESCALE_EN  when defined, a shared free-running prescaler
//   produces a one-cycle tick every PRESCALE clocks. The first tick comes
//   PRESCALE clocks after reset release. Counting and flipping then happen
//   only on tick cycles, while the agree-clear still happens on every clock.
//   When the macro is undefined there is no prescaler and every clock samples.
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int PRESCALE        = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] raw,
  output logic [N_BTN-1:0] stable,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] fall
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("button_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("button_debouncer: PRESCALE must be >= 2");
  end

  // Terminal count: a mismatch seen while cnt sits here flips the level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, no logic between the stages
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------------------
  logic tick;

`ifdef BTN_DEBOUNCE_PRESCALE_EN
  localparam int              PS_W   = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] pcnt;

  // Counter starts at 0 out of reset, so the first tick lands PRESCALE
  // clocks after release and then repeats every PRESCALE clocks.
  assign tick = (pcnt == PS_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Per-channel filter and edge strobes
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             mismatch;

    assign mismatch = (sync2[g] != stable_q);

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (mismatch) begin
        if (!tick) begin
          // Between ticks a disagreeing sample keeps the count it has.
          cnt_d = cnt_q;
        end else if (cnt_q == CNT_MAX) begin
          // Flip and clear on the same edge, so cnt never passes CNT_MAX.
          stable_d = sync2[g];
          rise_d   = sync2[g];
          fall_d   = ~sync2[g];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    assign stable[g] = stable_q;
    assign rise[g]   = rise_q;
    assign fall[g]   = fall_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int NB = 2;
  localparam int DC = 4;
  localparam int PS = 3;

  logic          clk;
  logic          reset;
  logic [NB-1:0] raw;
  logic [NB-1:0] stable;
  logic [NB-1:0] rise;
  logic [NB-1:0] fall;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .N_BTN(NB),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(3),
    .PRESCALE(PS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw(raw),
    .stable(stable),
    .rise(rise),
    .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. Rule: the input seen by the filter at a clock edge is the
  // raw value applied two edges earlier. The level flips once that delayed
  // input has differed from the level on DC consecutive sample ticks;
  // any agreeing clock resets the run.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] hist[$];
  int            run[NB];
  logic [NB-1:0] m_stable;
  logic [NB-1:0] m_rise;
  logic [NB-1:0] m_fall;
  int            clocks_since_reset;

  function automatic void model_reset();
    hist = '{2'b00, 2'b00};
    for (int c = 0; c < NB; c++) run[c] = 0;
    m_stable = '0;
    m_rise = '0;
    m_fall = '0;
    clocks_since_reset = 0;
  endfunction

  function automatic void model_edge(input logic [NB-1:0] r);
    logic [NB-1:0] seen;
    logic          smp;
    hist.push_back(r);
    seen = hist[hist.size() - 3];
    if (hist.size() > 8) void'(hist.pop_front());
    clocks_since_reset++;
`ifdef BTN_DEBOUNCE_PRESCALE_EN
    smp = ((clocks_since_reset % PS) == 0);
`else
    smp = 1'b1;
`endif
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < NB; c++) begin
      if (seen[c] == m_stable[c]) begin
        run[c] = 0;
      end else if (smp) begin
        run[c]++;
        if (run[c] == DC) begin
          m_stable[c] = seen[c];
          m_rise[c] = seen[c];
          m_fall[c] = ~seen[c];
          run[c] = 0;
        end
      end
    end
  endfunction

  // One clock with raw = r, then compare every output with the model.
  task automatic step(input logic [NB-1:0] r);
    raw = r;
    @(posedge clk);
    model_edge(r);
    #1;
    checks++;
    if (stable !== m_stable) begin
      errors++;
      $display("FAIL stable @%0t: got %b expected %b", $time, stable, m_stable);
    end
    checks++;
    if (rise !== m_rise) begin
      errors++;
      $display("FAIL rise @%0t: got %b expected %b", $time, rise, m_rise);
    end
    checks++;
    if (fall !== m_fall) begin
      errors++;
      $display("FAIL fall @%0t: got %b expected %b", $time, fall, m_fall);
    end
    checks++;
    if ((rise & fall) !== '0) begin
      errors++;
      $display("FAIL rise_and_fall @%0t: got %b expected 00", $time, rise & fall);
    end
  endtask

  task automatic do_reset(input logic [NB-1:0] r);
    raw = r;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if ({stable, rise, fall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stable=%b rise=%b fall=%b expected all 0",
               stable, rise, fall);
    end
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    do_reset(2'b11);
    for (int i = 0; i < 20; i++) begin
      step(2'b00);
      checks++;
      if ({stable, rise, fall} !== '0) begin
        errors++;
        $display("FAIL idle_zero cycle %0d: got %b%b%b expected 000000", i, stable, rise, fall);
      end
    end
  endtask

  task automatic test_single_rise();
    int n;
    do_reset(2'b00);
    n = 0;
    while (n < 40 && stable[0] !== 1'b1) begin
      step(2'b01);
      n++;
    end
`ifndef BTN_DEBOUNCE_PRESCALE_EN
    checks++;
    if (n != DC + 2) begin
      errors++;
      $display("FAIL single_latency: got %0d edges expected %0d", n, DC + 2);
    end
`endif
    checks++;
    if (rise !== 2'b01 || stable[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_rise: got rise=%b stable=%b expected rise=01 stable=01", rise, stable);
    end
    step(2'b01);
    checks++;
    if (rise !== 2'b00) begin
      errors++;
      $display("FAIL single_rise_width: got rise=%b expected 00", rise);
    end
    for (int i = 0; i < 3 * (DC + 2); i++) step(2'b01);
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int n;
    do_reset(2'b00);
    pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
    for (int i = 0; i < 5; i++) begin
      step({1'b0, pat[i]});
      checks++;
      if (stable[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_hold %0d: got stable[0]=%b expected 0", i, stable[0]);
      end
    end
    n = 0;
    while (n < 40 && stable[0] !== 1'b1) begin
      step(2'b01);
      n++;
    end
`ifndef BTN_DEBOUNCE_PRESCALE_EN
    checks++;
    if (n != DC + 2) begin
      errors++;
      $display("FAIL bounce_latency: got %0d edges expected %0d", n, DC + 2);
    end
`endif
  endtask

  task automatic test_both_channels();
    int n;
    do_reset(2'b00);
    n = 0;
    while (n < 40 && stable !== 2'b11) begin
      step(2'b11);
      n++;
    end
    checks++;
    if (rise !== 2'b11) begin
      errors++;
      $display("FAIL both_rise: got rise=%b expected 11 (after %0d edges)", rise, n);
    end
`ifndef BTN_DEBOUNCE_PRESCALE_EN
    checks++;
    if (n != DC + 2) begin
      errors++;
      $display("FAIL both_rise_latency: got %0d edges expected %0d", n, DC + 2);
    end
`endif
    for (int i = 0; i < 3; i++) step(2'b11);
    n = 0;
    while (n < 40 && stable !== 2'b00) begin
      step(2'b00);
      n++;
    end
    checks++;
    if (fall !== 2'b11) begin
      errors++;
      $display("FAIL both_fall: got fall=%b expected 11 (after %0d edges)", fall, n);
    end
`ifndef BTN_DEBOUNCE_PRESCALE_EN
    checks++;
    if (n != DC + 2) begin
      errors++;
      $display("FAIL both_fall_latency: got %0d edges expected %0d", n, DC + 2);
    end
`endif
  endtask

  task automatic test_reset_midcount();
    int n;
    do_reset(2'b00);
    for (int i = 0; i < 3; i++) step(2'b10);
    do_reset(2'b10);  // reset on the 4th edge, partial count discarded
    checks++;
    if (stable[1] !== 1'b0) begin
      errors++;
      $display("FAIL midcount_reset: got stable[1]=%b expected 0", stable[1]);
    end
    n = 0;
    while (n < 40 && stable[1] !== 1'b1) begin
      step(2'b10);
      n++;
    end
`ifndef BTN_DEBOUNCE_PRESCALE_EN
    checks++;
    if (n != DC + 2) begin
      errors++;
      $display("FAIL midcount_latency: got %0d edges expected %0d", n, DC + 2);
    end
`endif
  endtask

  task automatic test_random();
    logic [NB-1:0] r;
    do_reset(2'b00);
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NB; c++) begin
        if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
      end
      if ($urandom_range(0, 199) == 0) do_reset(r);
      else step(r);
    end
  endtask

  initial begin
    reset = 1'b1;
    raw = '0;
    model_reset();
    test_reset();
    test_single_rise();
    test_bounce();
    test_both_channels();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
